audio_adc_read: RTL and testbench
=================================

Name: audio_adc_read

Overview:
- Serial capture engine for the dual-channel audio ADC. It is the read-side counterpart of the DAC serial writer.
- On a start handshake it:
  - pulses CONVST,
  - waits for the ADC BUSY line to drop,
  - clocks one 32-bit SPI frame, shifting an 8-bit config word out on din and two 16-bit samples (ch A, then ch B) in on dout,
  - presents the samples with a one-cycle valid strobe.
- Sits between the ADC pins and the baseband sample path.

Parameters:
- CLK_DIV, 2, clk cycles per sclk half-period (≥1).
- CONV_CYCLES, 2, clk cycles convst is held high (≥1).
- BUSY_TIMEOUT, 255, max clk cycles to wait for busy low before aborting.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a conversion; accepted only when ready=1.
- cfg  in  8  ADC control word (command/channel bits); latched on accept, sent MSB first.
- ready  out  1  high when idle and able to accept start.
- valid  out  1  one-cycle strobe: data_a/data_b updated.
- err  out  1  one-cycle strobe: busy timeout, frame aborted.
- data_a  out  16  channel A sample (first 16 frame bits, MSB first).
- data_b  out  16  channel B sample (last 16 frame bits).
- convst  out  1  ADC conversion start, active high.
- busy  in  1  ADC converting, active high; double-flop synchronised internally.
- cs_n  out  1  ADC chip select, active low.
- sclk  out  1  serial clock, idles high.
- din  out  1  serial data to ADC.
- dout  in  1  serial data from ADC.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). All outputs are registered.
- Reset values:
  - ready=1, valid=0, err=0;
  - data_a=data_b=0;
  - convst=0, cs_n=1, sclk=1, din=0;
  - FSM in IDLE, all counters 0.
- Reset mid-operation: the cycle after reset is sampled, every output is at its reset value. A partial frame never updates data_a/data_b.
- FSM states: IDLE, CONV, WAIT_BUSY, SETUP, SHIFT, HOLD, DONE.
- IDLE:
  - ready=1.
  - If start=1, latch cfg, go to CONV. ready=0 from the next cycle.
  - start while ready=0 is ignored (no queuing).
- CONV: convst=1 for exactly CONV_CYCLES cycles, then WAIT_BUSY.
- WAIT_BUSY:
  - convst=0.
  - Synchronised busy=0 → SETUP next cycle.
  - Counter reaches BUSY_TIMEOUT → err=1 for one cycle, return to IDLE. data_a/data_b are unchanged and valid is not pulsed.
- SETUP: one cycle. cs_n=0, sclk=1, din=cfg[7].
- SHIFT: 32 bit periods of 2*CLK_DIV cycles each.
  - sclk=0 in the first CLK_DIV cycles, 1 in the second CLK_DIV cycles.
  - din changes only on an sclk falling edge. Bit k (k=0..31) carries cfg[7-k] for k<8, else 0.
  - dout is sampled on the clk cycle where sclk rises, into a 32-bit shift register, MSB first.
- HOLD: one cycle. cs_n=0, sclk=1.
- DONE:
  - cs_n=1, din=0.
  - data_a=shift[31:16], data_b=shift[15:0].
  - valid=1 for this cycle only; return to IDLE (ready=1 next cycle).
- Latency with busy already low (CLK_DIV=D, CONV_CYCLES=C), start accepted at cycle 0:
  - convst high in cycles 1..C;
  - WAIT_BUSY at C+1, SETUP at C+2;
  - SHIFT in cycles C+3..C+2+64D;
  - HOLD at C+3+64D;
  - valid at C+4+64D;
  - ready=1 at C+5+64D.
  - Defaults (C=2, D=2): valid at cycle 134.
- Busy sync: the 2-cycle synchroniser delay is included in the WAIT_BUSY exit. The state is entered at C+1 and exit is evaluated from the synchronised value.
- Back-to-back operation: start held high re-accepts on the single IDLE cycle after DONE.
- Exactly 32 rising sclk edges occur per completed frame. An aborted frame (timeout) produces 0 edges.

Decomposition:
- Shared package audio_if_pkg:
  - FSM state encoding;
  - FRAME_BITS=32, CFG_BITS=8, SAMPLE_BITS=16.
  - The DAC writer reuses the same constants.
- One natural sub-module, spi_bit_timer: generates sclk, the fall/rise strobes and the bit counter from CLK_DIV. The DAC writer can share it.

Test Plan:
- Basic read: ADC model returns 0xABCD then 0x1234, busy low 10 cycles after convst → valid pulse, data_a=0xABCD, data_b=0x1234, exactly 32 sclk rises, cs_n low only SETUP..HOLD.
- Config shift: cfg=0xA5 → din samples on the first 8 sclk rises = 1,0,1,0,0,1,0,1; din=0 for bits 8..31; din stable while sclk high.
- Latency: busy tied low, defaults → valid exactly 134 cycles after start accept, ready re-asserts at cycle 135.
- Busy timeout: busy stuck high → err pulse once, no sclk edges, cs_n stays 1, data_a/data_b hold previous values, ready=1 afterwards.
- Reset mid-SHIFT: assert reset at bit 12 → next cycle cs_n=1, sclk=1, ready=1, data_a/data_b=0. A following normal read returns correct data.
- Start held high / start while busy: start kept at 1 over two frames (0xFA5F/0x0001, then 0x8000/0x7FFF) → two valid pulses, each with the correct data. Extra start pulses during SHIFT are ignored.

Source files
------------

// File: rtl/audio_if_pkg.sv
// rtl/audio_if_pkg.sv - frame constants and FSM encoding shared by the audio ADC reader and DAC writer
package audio_if_pkg;

  localparam int FRAME_BITS  = 32;
  localparam int CFG_BITS    = 8;
  localparam int SAMPLE_BITS = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_WAIT_BUSY,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE
  } adc_state_t;

  // Chip select is asserted from SETUP through HOLD.
  function automatic logic in_frame(input adc_state_t s);
    return (s == ST_SETUP) || (s == ST_SHIFT) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/spi_bit_timer.sv
// rtl/spi_bit_timer.sv - sclk generator with rise/fall strobes and bit counter for one SPI frame
module spi_bit_timer
  import audio_if_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic sclk,
  output logic rise,
  output logic fall_next,
  output logic done
);

  localparam int PW = $clog2(2 * CLK_DIV + 1);
  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [PW-1:0] PH_RISE  = PW'(CLK_DIV);
  localparam logic [PW-1:0] PH_LAST  = PW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

  logic [PW-1:0] phase;
  logic [PW-1:0] phase_inc;
  logic [BW-1:0] bit_cnt;

  assign phase_inc = phase + PW'(1);
  // rise marks the first cycle with sclk high; fall_next marks the cycle before sclk drops
  assign rise      = run && (phase == PH_RISE);
  assign done      = run && (phase == PH_LAST) && (bit_cnt == BIT_LAST);
  assign fall_next = run && (phase == PH_LAST) && (bit_cnt != BIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      phase   <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b1;
    end else if (load) begin
      phase   <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
    end else if (run) begin
      if (phase == PH_LAST) begin
        phase <= '0;
        if (bit_cnt == BIT_LAST) begin
          bit_cnt <= '0;
          sclk    <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + BW'(1);
          sclk    <= 1'b0;
        end
      end else begin
        phase <= phase_inc;
        sclk  <= (phase_inc >= PH_RISE);
      end
    end else begin
      phase   <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b1;
    end
  end

endmodule

// File: rtl/audio_adc_read.sv
// rtl/audio_adc_read.sv - dual-channel audio ADC capture: convst, busy wait, 32-bit SPI frame, sample strobe
module audio_adc_read
  import audio_if_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int CONV_CYCLES  = 2,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CFG_BITS-1:0]    cfg,
  output logic                   ready,
  output logic                   valid,
  output logic                   err,
  output logic [SAMPLE_BITS-1:0] data_a,
  output logic [SAMPLE_BITS-1:0] data_b,
  output logic                   convst,
  input  logic                   busy,
  output logic                   cs_n,
  output logic                   sclk,
  output logic                   din,
  input  logic                   dout
);

  localparam int CW = 16;
  localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(BUSY_TIMEOUT - 1);

  adc_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic accept, timeout;
  logic busy_m, busy_s;
  logic [FRAME_BITS-1:0] tx_sr, rx_sr;
  logic bit_rise, bit_fall_next, frame_done;

  spi_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (state == ST_SETUP),
    .run      (state == ST_SHIFT),
    .sclk     (sclk),
    .rise     (bit_rise),
    .fall_next(bit_fall_next),
    .done     (frame_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    timeout = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = ST_CONV;
          cnt_n   = '0;
        end
      end
      ST_CONV: begin
        if (cnt == CONV_LAST) begin
          state_n = ST_WAIT_BUSY;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_WAIT_BUSY: begin
        if (!busy_s) begin
          state_n = ST_SETUP;
          cnt_n   = '0;
        end else if (cnt == WAIT_LAST) begin
          timeout = 1'b1;
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_SETUP: state_n = ST_SHIFT;
      ST_SHIFT: if (frame_done) state_n = ST_HOLD;
      ST_HOLD:  state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Pin-level outputs are decoded from the next state so they change in the same cycle as the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_m <= 1'b0;
      busy_s <= 1'b0;
      ready  <= 1'b1;
      valid  <= 1'b0;
      err    <= 1'b0;
      convst <= 1'b0;
      cs_n   <= 1'b1;
      din    <= 1'b0;
      data_a <= '0;
      data_b <= '0;
      tx_sr  <= '0;
      rx_sr  <= '0;
    end else begin
      busy_m <= busy;
      busy_s <= busy_m;
      ready  <= (state_n == ST_IDLE);
      valid  <= (state_n == ST_DONE);
      err    <= timeout;
      convst <= (state_n == ST_CONV);
      cs_n   <= !in_frame(state_n);

      if (accept) tx_sr <= {cfg, {(FRAME_BITS - CFG_BITS){1'b0}}};

      if (state == ST_SETUP) begin
        din <= tx_sr[FRAME_BITS-1];
      end else if (bit_fall_next) begin
        din   <= tx_sr[FRAME_BITS-2];
        tx_sr <= tx_sr << 1;
      end else if (state_n == ST_DONE) begin
        din <= 1'b0;
      end

      if (bit_rise) rx_sr <= {rx_sr[FRAME_BITS-2:0], dout};

      if (state_n == ST_DONE) begin
        data_a <= rx_sr[FRAME_BITS-1 -: SAMPLE_BITS];
        data_b <= rx_sr[SAMPLE_BITS-1:0];
      end
    end
  end

endmodule

// File: tb/tb_audio_adc_read.sv
// tb/tb_audio_adc_read.sv - randomized self-checking bench for audio_adc_read with a behavioural ADC
module tb_audio_adc_read;

  localparam int D     = 2;
  localparam int C     = 2;
  localparam int TO    = 255;
  localparam int LAT   = C + 4 + 64 * D;
  localparam int CSLOW = 2 + 64 * D;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  cfg = 8'h00;
  logic        busy = 1'b0;
  logic        dout = 1'b0;
  logic        ready, valid, err, convst, cs_n, sclk, din;
  logic [15:0] data_a, data_b;

  always #5 clk = ~clk;

  audio_adc_read #(
    .CLK_DIV(D),
    .CONV_CYCLES(C),
    .BUSY_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cfg(cfg),
    .ready(ready), .valid(valid), .err(err),
    .data_a(data_a), .data_b(data_b),
    .convst(convst), .busy(busy), .cs_n(cs_n),
    .sclk(sclk), .din(din), .dout(dout)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ADC model: busy after convst, frame words shifted out on sclk falling edges
  int          adc_mode = 1;
  int          busy_delay = 10;
  int          bcnt = 0;
  logic [31:0] adc_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] exp_din_q[$];
  logic [31:0] frame = 0;
  int          idx = 0;

  int          n_valid = 0, n_err = 0, n_conv = 0;
  int          rises = 0, cs_low = 0, stab_bad = 0;
  int          valid_cyc = 0, err_cyc = 0;
  logic [31:0] din_bits = 0;
  logic [31:0] e_data, e_din;
  logic        sclk_p = 1'b1, convst_p = 1'b0, cs_n_p = 1'b1, din_p = 1'b0;

  always @(negedge clk) begin
    case (adc_mode)
      0: busy = 1'b0;
      2: busy = 1'b1;
      default: begin
        if (convst) begin
          busy = 1'b1;
          bcnt = busy_delay;
        end else if (busy) begin
          if (bcnt == 0) busy = 1'b0;
          else bcnt--;
        end
      end
    endcase
    if (!cs_n && cs_n_p) begin
      frame = (adc_q.size() != 0) ? adc_q.pop_front() : 32'h0;
      idx = 0;
    end
    if (!cs_n && !sclk && sclk_p && idx < 32) begin
      dout = frame[31-idx];
      idx++;
    end

    if (convst && !convst_p) begin
      n_conv++;
      rises = 0;
      cs_low = 0;
      stab_bad = 0;
      din_bits = 0;
    end
    if (!cs_n) cs_low++;
    if (sclk && !sclk_p) begin
      rises++;
      din_bits = {din_bits[30:0], din};
    end
    if (sclk && sclk_p && !cs_n && !cs_n_p && din !== din_p) stab_bad++;
    if (valid) begin
      n_valid++;
      valid_cyc = cyc;
      check_eq("exp_avail", {31'b0, exp_data_q.size() != 0}, 1);
      if (exp_data_q.size() != 0) begin
        e_data = exp_data_q.pop_front();
        e_din  = exp_din_q.pop_front();
        check_eq("data_a", {16'h0, data_a}, {16'h0, e_data[31:16]});
        check_eq("data_b", {16'h0, data_b}, {16'h0, e_data[15:0]});
        check_eq("din_bits", din_bits, e_din);
      end
      check_eq("sclk_rises", rises, 32);
      check_eq("cs_low_cycles", cs_low, CSLOW);
      check_eq("din_stable", stab_bad, 0);
    end
    if (err) begin
      n_err++;
      err_cyc = cyc;
    end
    sclk_p   = sclk;
    convst_p = convst;
    cs_n_p   = cs_n;
    din_p    = din;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] c, input logic [15:0] a, input logic [15:0] b,
                       input bit expect_frame, output int t0);
    int k = 0;
    while (!ready && k < 2000) begin
      tick();
      k++;
    end
    check_eq("ready_before_start", {31'b0, ready}, 1);
    cfg   = c;
    start = 1'b1;
    t0    = cyc;
    if (expect_frame) begin
      adc_q.push_back({a, b});
      exp_data_q.push_back({a, b});
      exp_din_q.push_back({c, 24'h0});
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int target);
    int k = 0;
    while (n_valid < target && k < 3000) begin
      tick();
      k++;
    end
    check_eq("valid_seen", n_valid, target);
  endtask

  initial begin
    int t0, nv, ne, nc, v1, v2, k;
    logic [15:0] pa, pb;

    repeat (3) tick();
    check_eq("rst_ready", {31'b0, ready}, 1);
    check_eq("rst_valid", {31'b0, valid}, 0);
    check_eq("rst_err", {31'b0, err}, 0);
    check_eq("rst_data_a", {16'h0, data_a}, 0);
    check_eq("rst_data_b", {16'h0, data_b}, 0);
    check_eq("rst_convst", {31'b0, convst}, 0);
    check_eq("rst_cs_n", {31'b0, cs_n}, 1);
    check_eq("rst_sclk", {31'b0, sclk}, 1);
    check_eq("rst_din", {31'b0, din}, 0);
    reset = 1'b0;
    tick();

    // basic read
    adc_mode = 1;
    busy_delay = 10;
    issue(8'h3C, 16'hABCD, 16'h1234, 1'b1, t0);
    wait_valid(1);

    // config shift pattern
    busy_delay = $urandom_range(0, 20);
    issue(8'hA5, 16'($urandom), 16'($urandom), 1'b1, t0);
    wait_valid(2);

    // latency with busy tied low
    adc_mode = 0;
    issue(8'($urandom), 16'($urandom), 16'($urandom), 1'b1, t0);
    wait_valid(3);
    check_eq("latency_valid", valid_cyc - t0, LAT);
    check_eq("ready_in_done", {31'b0, ready}, 0);
    tick();
    check_eq("ready_after_done", {31'b0, ready}, 1);

    // random reads with a stray start pulse mid-frame
    for (int i = 0; i < 6; i++) begin
      adc_mode = $urandom_range(0, 1);
      busy_delay = $urandom_range(0, 30);
      nc = n_conv;
      nv = n_valid;
      issue(8'($urandom), 16'($urandom), 16'($urandom), 1'b1, t0);
      k = 0;
      while (rises < 5 && k < 500) begin
        tick();
        k++;
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_valid(nv + 1);
      check_eq("one_conv_per_frame", n_conv - nc, 1);
    end

    // busy stuck high -> timeout
    tick();
    pa = data_a;
    pb = data_b;
    nv = n_valid;
    ne = n_err;
    adc_mode = 2;
    issue(8'($urandom), 16'h0, 16'h0, 1'b0, t0);
    k = 0;
    while (n_err == ne && k < 1000) begin
      tick();
      k++;
    end
    check_eq("err_count", n_err - ne, 1);
    check_eq("err_latency_ok", {31'b0, (err_cyc - t0 >= TO) && (err_cyc - t0 <= TO + C + 8)}, 1);
    check_eq("to_rises", rises, 0);
    check_eq("to_cs_low", cs_low, 0);
    check_eq("to_data_a", {16'h0, data_a}, {16'h0, pa});
    check_eq("to_data_b", {16'h0, data_b}, {16'h0, pb});
    check_eq("to_no_valid", n_valid, nv);
    check_eq("to_ready", {31'b0, ready}, 1);
    tick();
    check_eq("err_one_cycle", {31'b0, err}, 0);

    // reset in the middle of SHIFT
    adc_mode = 1;
    busy_delay = 4;
    issue(8'($urandom), 16'($urandom) | 16'h8000, 16'($urandom) | 16'h0001, 1'b1, t0);
    k = 0;
    while (rises < 12 && k < 1000) begin
      tick();
      k++;
    end
    check_eq("reached_bit12", rises, 12);
    reset = 1'b1;
    tick();
    check_eq("mid_rst_cs_n", {31'b0, cs_n}, 1);
    check_eq("mid_rst_sclk", {31'b0, sclk}, 1);
    check_eq("mid_rst_ready", {31'b0, ready}, 1);
    check_eq("mid_rst_data_a", {16'h0, data_a}, 0);
    check_eq("mid_rst_data_b", {16'h0, data_b}, 0);
    check_eq("mid_rst_valid", {31'b0, valid}, 0);
    reset = 1'b0;
    adc_q.delete();
    exp_data_q.delete();
    exp_din_q.delete();
    tick();
    nv = n_valid;
    issue(8'($urandom), 16'($urandom), 16'($urandom), 1'b1, t0);
    wait_valid(nv + 1);

    // start held high across two back-to-back frames
    adc_mode = 0;
    k = 0;
    while (!ready && k < 100) begin
      tick();
      k++;
    end
    cfg = 8'h5A;
    adc_q.push_back(32'hFA5F_0001);
    exp_data_q.push_back(32'hFA5F_0001);
    exp_din_q.push_back({8'h5A, 24'h0});
    adc_q.push_back(32'h8000_7FFF);
    exp_data_q.push_back(32'h8000_7FFF);
    exp_din_q.push_back({8'h5A, 24'h0});
    nc = n_conv;
    nv = n_valid;
    start = 1'b1;
    wait_valid(nv + 1);
    v1 = valid_cyc;
    wait_valid(nv + 2);
    start = 1'b0;
    v2 = valid_cyc;
    check_eq("b2b_spacing", v2 - v1, LAT + 1);
    repeat (20) tick();
    check_eq("b2b_conv_count", n_conv - nc, 2);
    check_eq("b2b_valid_count", n_valid - nv, 2);
    check_eq("b2b_ready", {31'b0, ready}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
